// File: rtl/div32_seq_pkg.sv
// div_pkg: shared types and constants for the sequential 32-bit divider.
//   div_state_t : controller states (IDLE, CALC, FIXUP, DONE)
//   DIV_ITER    : restoring-division steps per operation
//   DIV_CNT_W   : width of the iteration counter
package div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } div_state_t;

  localparam int DIV_ITER  = 32;
  localparam int DIV_CNT_W = 6;

endpackage

// File: rtl/div32_seq_adder32.sv
// adder32: 32-bit ripple-carry adder used by the divider for trial
// subtraction (the caller inverts the subtrahend and forces c_in high).
//   a, b   : 32-bit addends
//   c_in   : carry into bit 0
//   sum    : 32-bit sum
//   c_out  : carry out of bit 31 (1 = no borrow when subtracting)
module adder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        c_in,
  output logic [31:0] sum,
  output logic        c_out
);

  logic [32:0] carry;

  assign carry[0] = c_in;

  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_bit
      assign sum[gi]       = a[gi] ^ b[gi] ^ carry[gi];
      assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign c_out = carry[32];

endmodule

// File: rtl/div32_seq.sv
// div32_seq: multi-cycle restoring divider, one quotient bit per clock.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : launch request, accepted only in IDLE
//   signed_op    : 1 = two's-complement divide, 0 = unsigned
//   RA, RB       : dividend, divisor (sampled with start)
//   LO, HI       : quotient, remainder (registered, held between ops)
//   busy         : high from the accepting edge until DONE is left
//   done         : one-cycle pulse when LO/HI are valid
//   div_by_zero  : set when the last operation had RB == 0
module div32_seq
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] RA,
  input  logic [WIDTH-1:0] RB,
  output logic [WIDTH-1:0] LO,
  output logic [WIDTH-1:0] HI,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam logic [DIV_CNT_W-1:0] LAST_ITER = DIV_CNT_W'(DIV_ITER - 1);

  div_state_t           state_reg;
  logic [DIV_CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0]     quo_reg;
  logic [WIDTH-1:0]     rem_reg;
  logic [WIDTH-1:0]     dvs_reg;
  logic                 neg_q_reg;
  logic                 neg_r_reg;
  logic                 zero_reg;

  logic [WIDTH-1:0]     ra_mag;
  logic [WIDTH-1:0]     rb_mag;
  logic [WIDTH:0]       r_shift;
  logic [WIDTH-1:0]     diff;
  logic                 carry;
  logic                 trial_ok;

  // Operand magnitudes; unsigned operands pass through untouched.
  assign ra_mag = (signed_op && RA[WIDTH-1]) ? (~RA + WIDTH'(1)) : RA;
  assign rb_mag = (signed_op && RB[WIDTH-1]) ? (~RB + WIDTH'(1)) : RB;

  // Upper 33 bits of {rem, quo} << 1.
  assign r_shift = {rem_reg, quo_reg[WIDTH-1]};

  adder32 u_trial (
    .a     (r_shift[WIDTH-1:0]),
    .b     (~dvs_reg),
    .c_in  (1'b1),
    .sum   (diff),
    .c_out (carry)
  );

  // The shifted-out bit 32 means R already exceeds any 32-bit divisor.
  assign trial_ok = carry | r_shift[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      quo_reg     <= '0;
      rem_reg     <= '0;
      dvs_reg     <= '0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      zero_reg    <= 1'b0;
      LO          <= '0;
      HI          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
            cnt_reg     <= '0;
            rem_reg     <= '0;
            dvs_reg     <= rb_mag;
            neg_q_reg   <= signed_op & (RA[WIDTH-1] ^ RB[WIDTH-1]);
            neg_r_reg   <= signed_op & RA[WIDTH-1];
            if (RB == '0) begin
              // Zero divisor bypasses CALC; the raw dividend is parked in
              // quo_reg so FIXUP can return it unchanged one edge later,
              // which gives the single-cycle done latency.
              zero_reg  <= 1'b1;
              quo_reg   <= RA;
              state_reg <= FIXUP;
            end else begin
              zero_reg  <= 1'b0;
              quo_reg   <= ra_mag;
              state_reg <= CALC;
            end
          end
        end

        CALC: begin
          rem_reg <= trial_ok ? diff : r_shift[WIDTH-1:0];
          quo_reg <= {quo_reg[WIDTH-2:0], trial_ok};
          cnt_reg <= cnt_reg + DIV_CNT_W'(1);
          if (cnt_reg == LAST_ITER) begin
            state_reg <= FIXUP;
          end
        end

        FIXUP: begin
          if (zero_reg) begin
            LO          <= '1;
            HI          <= quo_reg;
            div_by_zero <= 1'b1;
          end else begin
            // 0x80000000 / -1 naturally wraps back to 0x80000000 here.
            LO <= neg_q_reg ? (~quo_reg + WIDTH'(1)) : quo_reg;
            HI <= neg_r_reg ? (~rem_reg + WIDTH'(1)) : rem_reg;
          end
          done      <= 1'b1;
          state_reg <= DONE;
        end

        DONE: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div32_seq.sv
// Scoreboard bench for div32_seq: the stimulus process pushes expected
// results from an arithmetic reference model; a monitor pops on each done.
module tb_div32_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        signed_op;
  logic [31:0] RA;
  logic [31:0] RB;
  logic [31:0] LO;
  logic [31:0] HI;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dz;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  div32_seq #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .signed_op   (signed_op),
    .RA          (RA),
    .RB          (RB),
    .LO          (LO),
    .HI          (HI),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (cyc > 50000) begin
      $display("FAIL timeout: cycle %0d reached, required completion earlier", cyc);
      $fatal(1, "timeout");
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  // Reference: plain arithmetic on 64-bit signed values avoids the
  // overflow corner of 32-bit signed division and truncates toward zero.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t   e;
    longint qa, qb;
    e.a = a; e.b = b; e.s = s; e.cyc = 0;
    if (b == 32'd0) begin
      e.lo = 32'hFFFF_FFFF; e.hi = a; e.dz = 1'b1;
    end else if (s) begin
      qa = longint'($signed(a));
      qb = longint'($signed(b));
      e.lo = 32'(qa / qb);
      e.hi = 32'(qa % qb);
      e.dz = 1'b0;
    end else begin
      e.lo = a / b; e.hi = a % b; e.dz = 1'b0;
    end
    return e;
  endfunction

  // Monitor: each done pulse consumes one scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: got done with empty scoreboard at cycle %0d, required none", cyc);
      end else begin
        e = sb.pop_front();
        $display("txn a=%h b=%h s=%0d LO=%h HI=%h dz=%0d cyc=%0d",
                 e.a, e.b, e.s, LO, HI, div_by_zero, cyc);
        chk("LO", LO, e.lo);
        chk("HI", HI, e.hi);
        chk("div_by_zero", 32'(div_by_zero), 32'(e.dz));
        chk("latency", 32'(cyc), 32'(e.cyc));
        chk("busy_at_done", 32'(busy), 32'd1);
      end
    end
  end

  // Called at a negedge while the DUT is idle; returns one negedge after
  // the accepting edge.
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t e;
    RA = a; RB = b; signed_op = s; start = 1'b1;
    e = model(a, b, s);
    e.cyc = cyc + 1 + ((b == 32'd0) ? 1 : 33);
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      if (!busy) return;
      @(negedge clk);
    end
    n_checks++;
    $display("FAIL wait_idle: busy still %0d after 100 cycles, required 0", busy);
  endtask

  task automatic op(input logic [31:0] a, input logic [31:0] b, input logic s);
    launch(a, b, s);
    wait_idle();
  endtask

  initial begin
    logic [31:0] a, b;
    logic        s;
    rst_n = 1'b0; start = 1'b0; signed_op = 1'b0; RA = '0; RB = '0;
    repeat (3) @(negedge clk);
    chk("reset_LO", LO, 32'd0);
    chk("reset_HI", HI, 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_dz", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases.
    op(32'd100, 32'd7, 1'b0);
    op(32'hFFFF_FF9C, 32'd7, 1'b1);
    op(32'h1234_5678, 32'd0, 1'b0);
    chk("dz_held", 32'(div_by_zero), 32'd1);
    op(32'd9, 32'd3, 1'b0);
    op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    op(32'hFFFF_FFFF, 32'd1, 1'b0);
    op(32'hFFFF_FFFF, 32'd0, 1'b1);
    op(32'd7, 32'hFFFF_FFFE, 1'b1);

    // A start pulse mid-operation must be ignored.
    launch(32'd1000, 32'd71, 1'b0);
    repeat (9) @(negedge clk);
    RA = 32'd5; RB = 32'd1; signed_op = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);

    // Asynchronous reset mid-CALC clears everything at once.
    launch(32'hDEAD_BEEF, 32'd13, 1'b0);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_LO", LO, 32'd0);
    chk("midreset_HI", HI, 32'd0);
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_done", 32'(done), 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    op(32'd50, 32'd5, 1'b0);

    // Randomized operands, biased toward small and zero divisors.
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      s = 1'($urandom & 1);
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1, 2:    b = 32'($urandom_range(1, 255));
        3, 4:    b = -32'($urandom_range(1, 255));
        default: b = $urandom;
      endcase
      if (i % 7 == 3) a = 32'h8000_0000;
      op(a, b, s);
      chk("idle_done_low", 32'(done), 32'd0);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
